// File: rtl/fc_dma_reader_pkg.sv
// Shared fully-connected stage definitions: DMA reader state encoding,
// default widths, layer sizes and the parameter RAM map.
package fc_dma_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fc_dma_state_t;

   localparam int FC_DATA_WIDTH = 16;
   localparam int FC_ADDR_WIDTH = 10;
   localparam int FC_LAYER_SZ   = 7;

   localparam int FC_LAYER1_SIZE = 120;
   localparam int FC_LAYER2_SIZE = 84;
   localparam int FC_LAYER3_SIZE = 10;

   // Biases for all three layers sit back to back at the bottom of the RAM
   localparam logic [FC_ADDR_WIDTH-1:0] FC_BIAS1_BASE  = 10'h000;
   localparam logic [FC_ADDR_WIDTH-1:0] FC_BIAS2_BASE  = 10'h078;
   localparam logic [FC_ADDR_WIDTH-1:0] FC_BIAS3_BASE  = 10'h0CC;
   localparam logic [FC_ADDR_WIDTH-1:0] FC_WEIGHT_BASE = 10'h0D6;

endpackage

// File: rtl/fc_dma_reader_if.sv
// Request, parameter-RAM and output-stream signals of the FC DMA reader.
interface fc_dma_reader_if
   import fc_dma_reader_pkg::*;
#(
   parameter int MEM_ADDRESS_WIDTH = FC_ADDR_WIDTH,
   parameter int LAYER_SZ          = FC_LAYER_SZ,
   parameter int DATA_WIDTH        = FC_DATA_WIDTH
);

   logic                         DMA_read;
   logic [MEM_ADDRESS_WIDTH-1:0] DMA_address;
   logic [LAYER_SZ-1:0]          DMA_count;
   logic                         DMA_ready;
   logic                         busy;

   logic                         mem_rd_en;
   logic [MEM_ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]        mem_rdata;

   logic [DATA_WIDTH-1:0]        out_data;
   logic                         out_valid;
   logic [LAYER_SZ-1:0]          out_index;

   // The controller and RAM together form the master side
   modport master (
      output DMA_read, DMA_address, DMA_count, mem_rdata,
      input  DMA_ready, busy, mem_rd_en, mem_addr, out_data, out_valid, out_index
   );

   modport slave (
      input  DMA_read, DMA_address, DMA_count, mem_rdata,
      output DMA_ready, busy, mem_rd_en, mem_addr, out_data, out_valid, out_index
   );

endinterface

// File: rtl/fc_dma_reader.sv
// DMA read responder for the FC stage: fetches a batch of words from the
// parameter RAM and streams them onto the bus with their batch index.
module fc_dma_reader
   import fc_dma_reader_pkg::*;
#(
   parameter int MEM_ADDRESS_WIDTH = FC_ADDR_WIDTH,
   parameter int LAYER_SZ          = FC_LAYER_SZ,
   parameter int DATA_WIDTH        = FC_DATA_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clk_en,
   fc_dma_reader_if.slave bus
);

   fc_dma_state_t                state;
   logic [MEM_ADDRESS_WIDTH-1:0] base;
   logic [LAYER_SZ-1:0]          cnt;
   logic [LAYER_SZ-1:0]          k;
   logic                         rd_en_q;
   logic [MEM_ADDRESS_WIDTH-1:0] addr_q;
   logic                         valid_q;
   logic [LAYER_SZ-1:0]          index_q;
   logic                         ready_q;
   logic                         busy_q;
   logic [DATA_WIDTH-1:0]        data_hold;

   // valid/index trail the read strobe by one enabled cycle to line up with RAM data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         cnt       <= '0;
         k         <= '0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         data_hold <= '0;
      end else if (clk_en) begin
         valid_q <= rd_en_q;
         if (rd_en_q) begin
            index_q <= k;
         end
         if (valid_q) begin
            data_hold <= bus.mem_rdata;
         end
         case (state)
            IDLE: begin
               ready_q <= 1'b0;
               if (bus.DMA_read) begin
                  base   <= bus.DMA_address;
                  cnt    <= bus.DMA_count;
                  k      <= '0;
                  busy_q <= 1'b1;
                  if (bus.DMA_count != '0) begin
                     state   <= FETCH;
                     rd_en_q <= 1'b1;
                     addr_q  <= bus.DMA_address;
                  end else begin
                     state   <= DONE;
                     ready_q <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (k == cnt - LAYER_SZ'(1)) begin
                  rd_en_q <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  k      <= k + LAYER_SZ'(1);
                  addr_q <= base + MEM_ADDRESS_WIDTH'(k) + MEM_ADDRESS_WIDTH'(1);
               end
            end
            DRAIN: begin
               state   <= DONE;
               ready_q <= 1'b1;
            end
            DONE: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A stalled cycle must not clock the RAM, so the strobe is qualified here
   assign bus.mem_rd_en = rd_en_q & clk_en;
   assign bus.mem_addr  = addr_q;
   assign bus.out_valid = valid_q;
   assign bus.out_index = index_q;
   assign bus.out_data  = valid_q ? bus.mem_rdata : data_hold;
   assign bus.DMA_ready = ready_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fc_dma_reader.sv
// Randomised self-checking bench for fc_dma_reader against a batch-level
// model of the expected read, stream and completion timing.
module tb_fc_dma_reader;

   logic clk;
   logic rst;
   logic clk_en;
   int   tests;
   int   fails;
   int   cycle_no;

   logic [15:0] ram [0:1023];

   fc_dma_reader_if bus ();

   fc_dma_reader dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .bus    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle_no <= cycle_no + 1;

   // One-cycle-latency synchronous RAM, gated by the same clock enable
   always @(posedge clk) begin
      if (clk_en && bus.mem_rd_en) begin
         bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Runs one batch from mid-cycle; lead is the number of edges before the capture edge
   task automatic test_batch(input logic [9:0] base, input logic [6:0] cnt, input int lead,
                             input int stall_at, input int stall_len, input bit keep_read,
                             output int ready_at, output int first_rd_at);
      int          ec;
      int          ready_ec;
      int          ready_raw;
      int          exp_ready_ec;
      int          exp_ready_raw;
      bit          seen;
      bit          busy_ok;
      bit          gate_ok;
      logic [9:0]  rd_addr[$];
      int          rd_ec[$];
      logic [15:0] o_data[$];
      logic [6:0]  o_idx[$];
      int          o_ec[$];
      logic [9:0]  ea;

      clk_en          = 1'b1;
      bus.DMA_read    = 1'b1;
      bus.DMA_address = base;
      bus.DMA_count   = cnt;
      repeat (lead + 1) @(posedge clk);
      #1;
      bus.DMA_read    = keep_read;
      bus.DMA_address = 10'($urandom);
      bus.DMA_count   = 7'($urandom);

      ec = 1; seen = 1'b0; ready_ec = -1; ready_raw = -1;
      busy_ok = 1'b1; gate_ok = 1'b1; ready_at = -1; first_rd_at = -1;
      for (int c = 1; c <= int'(cnt) + stall_len + 8 && !seen; c++) begin
         clk_en = !(c >= stall_at && c < stall_at + stall_len);
         @(negedge clk);
         if (!clk_en) begin
            if (bus.mem_rd_en) gate_ok = 1'b0;
         end else begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.mem_rd_en) begin
               if (first_rd_at < 0) first_rd_at = cycle_no;
               rd_addr.push_back(bus.mem_addr);
               rd_ec.push_back(ec);
            end
            if (bus.out_valid) begin
               o_data.push_back(bus.out_data);
               o_idx.push_back(bus.out_index);
               o_ec.push_back(ec);
            end
            if (bus.DMA_ready) begin
               seen = 1'b1; ready_ec = ec; ready_raw = c; ready_at = cycle_no;
            end
            ec++;
         end
         if (!seen) begin
            @(posedge clk);
            #1;
         end
      end
      clk_en = 1'b1;

      exp_ready_ec  = (cnt == 7'd0) ? 1 : int'(cnt) + 2;
      exp_ready_raw = (stall_len > 0 && stall_at <= exp_ready_ec) ? exp_ready_ec + stall_len : exp_ready_ec;

      tests++;
      if (ready_ec !== exp_ready_ec) begin
         fails++;
         $display("[TB] FAIL ready_cycle: got %0d, expected %0d (base %h count %0d)", ready_ec, exp_ready_ec, base, cnt);
      end
      tests++;
      if (ready_raw !== exp_ready_raw) begin
         fails++;
         $display("[TB] FAIL ready_stall_delay: got cycle %0d, expected %0d (stall %0d+%0d)", ready_raw, exp_ready_raw, stall_at, stall_len);
      end
      tests++;
      if (!busy_ok) begin
         fails++;
         $display("[TB] FAIL busy: got 0 during batch, expected 1 (base %h count %0d)", base, cnt);
      end
      tests++;
      if (!gate_ok) begin
         fails++;
         $display("[TB] FAIL rd_en_gating: got mem_rd_en=1 with clk_en=0, expected 0");
      end
      tests++;
      if (rd_addr.size() != int'(cnt)) begin
         fails++;
         $display("[TB] FAIL read_count: got %0d, expected %0d", rd_addr.size(), cnt);
      end
      for (int i = 0; i < rd_addr.size() && i < int'(cnt); i++) begin
         ea = 10'(int'(base) + i);
         tests++;
         if (rd_addr[i] !== ea || rd_ec[i] != i + 1) begin
            fails++;
            $display("[TB] FAIL read_%0d: got addr %h at cycle %0d, expected addr %h at cycle %0d", i, rd_addr[i], rd_ec[i], ea, i + 1);
         end
      end
      tests++;
      if (o_data.size() != int'(cnt)) begin
         fails++;
         $display("[TB] FAIL word_count: got %0d, expected %0d", o_data.size(), cnt);
      end
      for (int i = 0; i < o_data.size() && i < int'(cnt); i++) begin
         ea = 10'(int'(base) + i);
         tests++;
         if (o_data[i] !== ram[ea] || o_idx[i] !== 7'(i) || o_ec[i] != i + 2) begin
            fails++;
            $display("[TB] FAIL word_%0d: got data %h idx %0d cycle %0d, expected data %h idx %0d cycle %0d", i, o_data[i], o_idx[i], o_ec[i], ram[ea], i, i + 2);
         end
      end
   endtask

   task automatic test_reset;
      #2;
      tests++;
      if ({bus.DMA_ready, bus.busy, bus.mem_rd_en, bus.out_valid} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_flags: got %b, expected 0000", {bus.DMA_ready, bus.busy, bus.mem_rd_en, bus.out_valid});
      end
      tests++;
      if (bus.mem_addr !== 10'h000 || bus.out_data !== 16'h0000 || bus.out_index !== 7'd0) begin
         fails++;
         $display("[TB] FAIL reset_values: got addr %h data %h idx %0d, expected 0 0 0", bus.mem_addr, bus.out_data, bus.out_index);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
         fails++;
         $display("[TB] FAIL idle_after_reset: got busy %b rd_en %b, expected 0 0", bus.busy, bus.mem_rd_en);
      end
   endtask

   task automatic test_basic;
      int r, f;
      ram[10'h010] = 16'h000A;
      ram[10'h011] = 16'h000B;
      ram[10'h012] = 16'h000C;
      test_batch(10'h010, 7'd3, 0, 0, 0, 1'b0, r, f);
      bus.DMA_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (bus.DMA_ready !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL ready_pulse_width: got ready %b busy %b after pulse, expected 0 0", bus.DMA_ready, bus.busy);
      end
      tests++;
      if (bus.out_data !== 16'h000C) begin
         fails++;
         $display("[TB] FAIL out_data_hold: got %h, expected 000c", bus.out_data);
      end
   endtask

   task automatic test_back_to_back;
      int r1, f1, r2, f2;
      test_batch(10'h100, 7'd2, 0, 0, 0, 1'b1, r1, f1);
      test_batch(10'h020, 7'd3, 1, 0, 0, 1'b0, r2, f2);
      tests++;
      if (f2 - r1 != 2) begin
         fails++;
         $display("[TB] FAIL back_to_back_gap: got %0d cycles, expected 2", f2 - r1);
      end
      bus.DMA_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_zero_count;
      int r, f;
      test_batch(10'h155, 7'd0, 0, 0, 0, 1'b0, r, f);
      tests++;
      if (f != -1) begin
         fails++;
         $display("[TB] FAIL zero_count_read: got read at cycle %0d, expected none", f);
      end
      bus.DMA_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_wrap;
      int r, f;
      test_batch(10'h3FE, 7'd4, 0, 0, 0, 1'b0, r, f);
      bus.DMA_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_stall;
      int r, f;
      test_batch(10'h0A0, 7'd5, 0, 3, 2, 1'b0, r, f);
      bus.DMA_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_mid_reset;
      int r, f;
      clk_en          = 1'b1;
      bus.DMA_read    = 1'b1;
      bus.DMA_address = 10'h200;
      bus.DMA_count   = 7'd6;
      @(posedge clk);
      #1 bus.DMA_read = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.mem_rd_en !== 1'b1) begin
         fails++;
         $display("[TB] FAIL pre_reset_active: got valid %b rd_en %b, expected 1 1", bus.out_valid, bus.mem_rd_en);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({bus.DMA_ready, bus.busy, bus.mem_rd_en, bus.out_valid} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL mid_reset_flags: got %b, expected 0000", {bus.DMA_ready, bus.busy, bus.mem_rd_en, bus.out_valid});
      end
      tests++;
      if (bus.mem_addr !== 10'h000 || bus.out_data !== 16'h0000 || bus.out_index !== 7'd0) begin
         fails++;
         $display("[TB] FAIL mid_reset_values: got addr %h data %h idx %0d, expected 0 0 0", bus.mem_addr, bus.out_data, bus.out_index);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL discard_inflight: got out_valid %b, expected 0", bus.out_valid);
      end
      #2 rst = 1'b0;
      @(negedge clk);
      test_batch(10'h055, 7'd1, 0, 0, 0, 1'b0, r, f);
      tests++;
      if (r - f != 2) begin
         fails++;
         $display("[TB] FAIL post_reset_turnaround: got ready %0d cycles after read, expected 2", r - f);
      end
      bus.DMA_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_random;
      int r, f, n, sa, sl;
      logic [9:0] b;
      for (int it = 0; it < 20; it++) begin
         b  = 10'($urandom);
         n  = $urandom_range(0, 12);
         sa = $urandom_range(1, n + 3);
         sl = $urandom_range(0, 3);
         test_batch(b, 7'(n), (it == 0) ? 0 : 1, sa, sl, 1'($urandom), r, f);
      end
      bus.DMA_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      tests           = 0;
      fails           = 0;
      cycle_no        = 0;
      rst             = 1'b1;
      clk_en          = 1'b1;
      bus.DMA_read    = 1'b0;
      bus.DMA_address = '0;
      bus.DMA_count   = '0;
      for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);

      test_reset();
      test_basic();
      test_back_to_back();
      test_zero_count();
      test_wrap();
      test_stall();
      test_mid_reset();
      test_random();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fc_dma_reader.md
# fc_dma_reader

Memory-side responder for the fully-connected stage's DMA request interface. It accepts a read request (base address plus word count) from the FC controller, drives a one-cycle-latency synchronous weight/bias RAM, streams the returned words onto the datapath bus with a per-word index, and pulses `DMA_ready` once the whole batch has been delivered. It sits between the FC controller and the parameter RAM, and is the source selected when the bus data source is DMA.

## Interface
Parameters:
- `MEM_ADDRESS_WIDTH`, 10: RAM address width.
- `LAYER_SZ`, 7: width of the count and index fields.
- `DATA_WIDTH`, 16: RAM word width.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clk_en`  in  1: clock enable; when low, all state and outputs hold.
- `DMA_read`  in  1: level request from the controller.
- `DMA_address`  in  MEM_ADDRESS_WIDTH: base address, sampled at request capture.
- `DMA_count`  in  LAYER_SZ: number of words, sampled at request capture.
- `DMA_ready`  out  1: one-cycle pulse, batch complete.
- `busy`  out  1: high from capture until the `DMA_ready` pulse, inclusive.
- `mem_rd_en`  out  1: RAM read strobe.
- `mem_addr`  out  MEM_ADDRESS_WIDTH: RAM read address.
- `mem_rdata`  in  DATA_WIDTH: RAM data, valid one enabled cycle after the `mem_rd_en` cycle.
- `out_data`  out  DATA_WIDTH: streamed word to the bus.
- `out_valid`  out  1: `out_data` valid this cycle.
- `out_index`  out  LAYER_SZ: position of `out_data` within the batch, 0-based.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - If `DMA_read`=1, capture `base`=`DMA_address` and `cnt`=`DMA_count`, and clear `k`.
  - Go to FETCH if `cnt`≠0, otherwise go to DONE.
- FETCH:
  - Assert `mem_rd_en` with `mem_addr`=`base`+`k`. The add is modulo 2^MEM_ADDRESS_WIDTH and wraps silently.
  - Increment `k`. When `k`=`cnt`-1 is issued, go to DRAIN.
- Output stream:
  - Each read issued in FETCH produces `out_valid`=1 on the following enabled cycle.
  - On that cycle, `out_data` equals `mem_rdata` and `out_index` equals that read's `k`.
- DRAIN: present the final word (`out_valid`=1), then go to DONE.
- DONE:
  - `DMA_ready`=1 for exactly one cycle, then go to IDLE.
  - `cnt`=0 reaches DONE directly from IDLE, so `DMA_ready` pulses with no `out_valid`.
- Re-request: the controller holds `DMA_read` high and updates `DMA_address`/`DMA_count` on the edge where it sees `DMA_ready`. The IDLE cycle after DONE therefore samples the new request. Back-to-back batches need no gap beyond that one IDLE cycle.
- `DMA_read` is ignored outside IDLE: a transfer always completes and there is no abort. Changes to `DMA_address`/`DMA_count` mid-transfer have no effect.
- `out_data` holds its last value while `out_valid`=0.
- `clk_en`=0: state, `k`, and all registered outputs freeze, and `mem_rd_en` is forced to 0. The RAM must be gated by the same `clk_en`.
- Reset, asynchronous and effective mid-transfer:
  - State goes to IDLE; `k`, `base` and `cnt` go to 0.
  - `DMA_ready`, `busy`, `mem_rd_en`, `out_valid`, `mem_addr`, `out_data` and `out_index` all go to 0.
  - An in-flight RAM word is discarded.

## Timing
- Request captured at edge 0. With `clk_en` always high:
  - `mem_rd_en` is high for cycles 1..N.
  - `out_valid` is high for cycles 2..N+1.
  - `DMA_ready` pulses in cycle N+2.
  - IDLE in cycle N+3, where the next request is sampled.
- Batch turnaround is N+3 cycles; throughput is one word per cycle.
- N=1: read in cycle 1, valid in cycle 2, ready in cycle 3.
- N=0: ready in cycle 1.
- Stalls (`clk_en`=0) add cycles one-for-one and do not reorder events.

## Structure
- Shared FC package holds:
  - The state encoding.
  - The `DATA_WIDTH` default.
  - The layer-size constants (120, 84, 10) and the RAM map base addresses for bias and weights, which the controller also uses.
- No sub-module; a single FSM with a word counter and a one-stage valid/index delay register.

## Test plan
- Request base=0x010, count=3, RAM[0x010..0x012]=0xA,0xB,0xC:
  - `mem_addr` 0x010,0x011,0x012 in cycles 1..3.
  - `out_data` A,B,C with index 0,1,2 in cycles 2..4.
  - `DMA_ready` in cycle 5 only.
- `DMA_read` held high and the address changed to 0x020 on the ready edge: the second batch starts fetching 0x020 exactly two cycles after the first `DMA_ready`.
- count=0: `DMA_ready` one cycle after capture, no `mem_rd_en`, no `out_valid`.
- base=0x3FE, count=4: `mem_addr` sequence 0x3FE,0x3FF,0x000,0x001.
- `clk_en` low for 2 cycles mid-FETCH of count=5: same 5 words in order, `DMA_ready` delayed by exactly 2 cycles.
- `rst` asserted mid-transfer between clock edges: all outputs 0 immediately; after release, a new count=1 request completes normally in 3 cycles.
